// File: rtl/reset_sequencer_pkg.sv
// Shared types and constant helpers for the multi-domain reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      COLD  = 3'd0,
      WAIT  = 3'd1,
      STAGE = 3'd2,
      RUN   = 3'd3,
      FAULT = 3'd4
   } rseq_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((32'sd1 <<< result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Domain handshake bundle: ready inputs and soft restart in, resets and status out.
interface reset_sequencer_if #(parameter int NUM_CH = 4);

   logic [NUM_CH-1:0] ch_ready;
   logic              soft_rst_req;
   logic [NUM_CH-1:0] rst_out;
   logic              done;
   logic [NUM_CH-1:0] fault;
   logic [2:0]        stage;

   modport master (output ch_ready, soft_rst_req, input rst_out, done, fault, stage);
   modport slave  (input ch_ready, soft_rst_req, output rst_out, done, fault, stage);

endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for the asynchronous per-domain ready/lock inputs.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_r;
   logic [W-1:0] sync_r;

   // Metastability filter, cleared with the synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_r <= {W{1'b0}};
         sync_r <= {W{1'b0}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_CH reset domains in index order after a cold hold, each gated on
// its own ready, re-sequencing from the lowest domain that loses ready.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int                NUM_CH       = 4,
   parameter int                HOLD_CYCLES  = 16383,
   parameter int                STAGE_CYCLES = 256,
   parameter int                TIMEOUT      = 1048575,
   parameter logic [NUM_CH-1:0] READY_USED   = {NUM_CH{1'b1}}
) (
   input logic               clk200,
   input logic               sys_rst_n,
   reset_sequencer_if.slave  bus
);

   localparam int MAX_HS  = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
   localparam int MAX_CNT = (MAX_HS > TIMEOUT) ? MAX_HS : TIMEOUT;
   localparam int CNT_W   = clog2(MAX_CNT);

   rseq_state_t       state_r, state_nx_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
   logic [2:0]        idx_r, idx_nx_s;
   logic [NUM_CH-1:0] rst_out_r, rst_out_nx_s;
   logic              done_r, done_nx_s;
   logic [NUM_CH-1:0] fault_r, fault_nx_s;

   logic [NUM_CH-1:0] rdy_sync_s, rdy_eff_s, idx_onehot_s;
   logic [NUM_CH-1:0] loss_vec_s, loss_mask_s;
   logic [2:0]        loss_idx_s;
   logic              rdy_idx_s;

   sync_2ff #(.W(NUM_CH)) u_rdy_sync (
      .clk   (clk200),
      .rst_n (sys_rst_n),
      .d     (bus.ch_ready),
      .q     (rdy_sync_s)
   );

   assign rdy_eff_s = rdy_sync_s | ~READY_USED;

   // Lowest released domain that lost ready, and the mask of it plus all later domains.
   always_comb begin
      loss_vec_s   = ~rst_out_r & ~rdy_eff_s;
      loss_idx_s   = 3'd0;
      loss_mask_s  = {NUM_CH{1'b0}};
      idx_onehot_s = {NUM_CH{1'b0}};
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (loss_vec_s[i]) begin
            loss_idx_s = 3'(i);
         end else begin
            loss_idx_s = loss_idx_s;
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         loss_mask_s[i]  = (3'(i) >= loss_idx_s);
         idx_onehot_s[i] = (3'(i) == idx_r);
      end
      rdy_idx_s = |(rdy_eff_s & idx_onehot_s);
   end

   // Next-state logic: soft restart, then ready loss, then per-state sequencing.
   always_comb begin
      state_nx_s   = state_r;
      cnt_nx_s     = cnt_r;
      idx_nx_s     = idx_r;
      rst_out_nx_s = rst_out_r;
      done_nx_s    = done_r;
      fault_nx_s   = fault_r;
      if (bus.soft_rst_req) begin
         state_nx_s   = COLD;
         cnt_nx_s     = {CNT_W{1'b0}};
         idx_nx_s     = 3'd0;
         rst_out_nx_s = {NUM_CH{1'b1}};
         done_nx_s    = 1'b0;
         fault_nx_s   = {NUM_CH{1'b0}};
      end else if ((|loss_vec_s) && (state_r != COLD)) begin
         state_nx_s   = WAIT;
         cnt_nx_s     = {CNT_W{1'b0}};
         idx_nx_s     = loss_idx_s;
         rst_out_nx_s = rst_out_r | loss_mask_s;
         done_nx_s    = 1'b0;
      end else begin
         case (state_r)
            COLD: begin
               if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
                  state_nx_s = WAIT;
                  cnt_nx_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            WAIT: begin
               if (rdy_idx_s) begin
                  state_nx_s = STAGE;
                  cnt_nx_s   = {CNT_W{1'b0}};
               end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                  state_nx_s = FAULT;
                  cnt_nx_s   = {CNT_W{1'b0}};
                  fault_nx_s = fault_r | idx_onehot_s;
               end else begin
                  cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            STAGE: begin
               if (!rdy_idx_s) begin
                  state_nx_s = WAIT;
                  cnt_nx_s   = {CNT_W{1'b0}};
               end else if (cnt_r == CNT_W'(STAGE_CYCLES - 1)) begin
                  rst_out_nx_s = rst_out_r & ~idx_onehot_s;
                  cnt_nx_s     = {CNT_W{1'b0}};
                  if (idx_r == 3'(NUM_CH - 1)) begin
                     state_nx_s = RUN;
                     done_nx_s  = 1'b1;
                  end else begin
                     state_nx_s = WAIT;
                     idx_nx_s   = idx_r + 3'd1;
                  end
               end else begin
                  cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            RUN:     state_nx_s = RUN;
            FAULT:   state_nx_s = FAULT;
            default: state_nx_s = COLD;
         endcase
      end
   end

   // State and output registers; sys_rst_n is sampled on clk200.
   always_ff @(posedge clk200) begin
      if (!sys_rst_n) begin
         state_r   <= COLD;
         cnt_r     <= {CNT_W{1'b0}};
         idx_r     <= 3'd0;
         rst_out_r <= {NUM_CH{1'b1}};
         done_r    <= 1'b0;
         fault_r   <= {NUM_CH{1'b0}};
      end else begin
         state_r   <= state_nx_s;
         cnt_r     <= cnt_nx_s;
         idx_r     <= idx_nx_s;
         rst_out_r <= rst_out_nx_s;
         done_r    <= done_nx_s;
         fault_r   <= fault_nx_s;
      end
   end

   assign bus.rst_out = rst_out_r;
   assign bus.done    = done_r;
   assign bus.fault   = fault_r;
   assign bus.stage   = idx_r;

endmodule
